pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/mips_pkg.sv | 20 ++
 rtl/next_pc_logic.sv | 30 +++
 rtl/pc_fetch.sv | 89 ++++++++
 tb/tb_pc_fetch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding,
// reset PC default and small address helpers.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  // Instruction addresses are always word aligned; clear the byte offset.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: J-type target, PC-relative branch or
// sequential, all arithmetic modulo 2^32.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] i_pcplus4,
  input  logic [25:0]     i_jidx,
  input  logic [XLEN-1:0] i_signimm,
  input  logic            i_jump,
  input  logic            i_pcsrc,
  output logic [XLEN-1:0] o_next_pc
);

  logic [XLEN-1:0] w_jump_target;
  logic [XLEN-1:0] w_branch_target;

  // Jump stays within the 256 MB region of the delay-slot address.
  assign w_jump_target   = {i_pcplus4[31:28], i_jidx, 2'b00};
  assign w_branch_target = i_pcplus4 + (i_signimm << 2);

  always_comb begin
    o_next_pc = i_pcplus4;
    if (i_jump) begin
      o_next_pc = w_jump_target;
    end else if (i_pcsrc) begin
      o_next_pc = w_branch_target;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Single-outstanding-request instruction fetch unit: holds the PC, issues
// one memory request per instruction and presents the registered word.
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            pcsrc,
  input  logic            jump,
  input  logic [XLEN-1:0] signimm,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_pcplus4;
  logic            w_capture;
  logic            w_take;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  w_state_next = ST_FETCH;
      ST_FETCH: if (imem_ready) w_state_next = ST_VALID;
      ST_VALID: if (advance)    w_state_next = ST_FETCH;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (r_state == ST_FETCH);
    instr_valid = (r_state == ST_VALID);
    w_capture   = (r_state == ST_FETCH) && imem_ready;
    w_take      = (r_state == ST_VALID) && advance;
  end

  assign w_pcplus4 = r_pc + 32'd4;

  next_pc_logic u_next_pc (
    .i_pcplus4 (w_pcplus4),
    .i_jidx    (r_instr[25:0]),
    .i_signimm (signimm),
    .i_jump    (jump),
    .i_pcsrc   (pcsrc),
    .o_next_pc (w_next_pc)
  );

  // Reset wins over a same-cycle imem_ready, so a late response is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= word_align(RESET_PC);
      r_instr <= '0;
    end else begin
      if (w_capture) begin
        r_instr <= imem_rdata;
      end
      if (w_take) begin
        r_pc <= word_align(w_next_pc);
      end
    end
  end

  assign pc        = r_pc;
  assign pcplus4   = w_pcplus4;
  assign imem_addr = word_align(r_pc);
  assign instr     = r_instr;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed literal checks plus randomized
// traffic compared every cycle against a behavioural fetch model.
module tb_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        advance;
  logic        pcsrc;
  logic        jump;
  logic [31:0] signimm;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcplus4;

  int n_vec = 0;
  int n_err = 0;

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (advance),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .signimm     (signimm),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pcplus4     (pcplus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one instruction in flight at a time, tracked as
  // "booting", "waiting for memory" or "holding a valid word".
  logic        m_known = 1'b0;
  logic        m_boot  = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_instr = '0;

  function automatic logic [31:0] model_target(input logic [31:0] p, input logic [31:0] ins,
                                               input logic j, input logic b,
                                               input logic [31:0] imm);
    logic [31:0] seq;
    seq = p + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if (b) return seq + imm * 4;
    return seq;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known <= 1'b1;
      m_boot  <= 1'b1;
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_pc    <= RST_PC;
      m_instr <= '0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
      m_busy <= 1'b1;
    end else if (m_busy) begin
      if (imem_ready) begin
        m_instr <= imem_rdata;
        m_valid <= 1'b1;
        m_busy  <= 1'b0;
        $display("fetch  pc=%h instr=%h", m_pc, imem_rdata);
      end
    end else if (m_valid && advance) begin
      m_pc    <= model_target(m_pc, m_instr, jump, pcsrc, signimm);
      m_valid <= 1'b0;
      m_busy  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("imem_req",    {31'b0, imem_req},    {31'b0, m_busy});
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("pc",          pc,                   m_pc);
      chk("imem_addr",   imem_addr,            m_pc);
      chk("pcplus4",     pcplus4,              m_pc + 32'd4);
      chk("instr",       instr,                m_instr);
    end
  end

  task automatic do_adv(input logic j, input logic b, input logic [31:0] imm);
    advance = 1'b1;
    jump    = j;
    pcsrc   = b;
    signimm = imm;
    @(negedge clk);
    $display("advance jump=%0b pcsrc=%0b imm=%h -> pc=%h", j, b, imm, pc);
    advance = 1'b0;
    jump    = 1'($urandom);
    pcsrc   = 1'($urandom);
    signimm = $urandom;
  endtask

  task automatic do_fetch(input logic [31:0] word, input int gap);
    bit got;
    imem_ready = 1'b0;
    repeat (gap) @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = word;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = instr_valid;
    end
    if (!got) chk("fetch_timeout", 32'd0, 32'd1);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    advance    = 1'b0;
    pcsrc      = 1'b0;
    jump       = 1'b0;
    signimm    = '0;
    imem_rdata = '0;
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req",   {31'b0, imem_req},    32'd0);
    chk("rst_pc",    pc,                   32'h0);
    chk("rst_instr", instr,                32'h0);

    // First fetch after reset, with a one-cycle turnaround.
    rst_n      = 1'b1;
    imem_rdata = 32'h2008_0005;
    @(negedge clk);
    chk("first_req",  {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr,         32'h0);
    @(negedge clk);
    chk("first_instr", instr,               32'h2008_0005);
    chk("first_valid", {31'b0, instr_valid}, 32'd1);
    imem_ready = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_adv(1'b0, 1'b0, $urandom);
      do_fetch($urandom, i);
    end
    chk("seq_pc10", pc, 32'h10);
    do_adv(1'b0, 1'b0, 32'h0);
    chk("seq_addr14", imem_addr, 32'h14);

    do_fetch(32'h0800_0010, 1);
    do_adv(1'b1, 1'b0, 32'h0);
    chk("jump_40", pc, 32'h40);
    do_fetch($urandom, 0);
    do_adv(1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("branch_back", pc, 32'h40);
    do_fetch($urandom, 2);
    do_adv(1'b0, 1'b1, 32'h3);
    chk("branch_fwd", pc, 32'h50);
    do_fetch(32'h0000_0000, 0);
    do_adv(1'b0, 1'b1, 32'h03FF_FFEB);
    chk("branch_far", pc, 32'h1000_0000);
    do_fetch(32'h0800_0100, 0);
    do_adv(1'b1, 1'b1, 32'h5);
    chk("jump_prio", pc, 32'h1000_0400);

    // Memory stall, then decode stall with ignored control inputs.
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mstall_req",  {31'b0, imem_req}, 32'd1);
      chk("mstall_addr", imem_addr,         32'h1000_0400);
    end
    do_fetch(32'hDEAD_BEEF, 0);
    for (int i = 0; i < 10; i++) begin
      jump    = 1'($urandom);
      pcsrc   = 1'($urandom);
      signimm = $urandom;
      @(negedge clk);
      chk("dstall_instr", instr,               32'hDEAD_BEEF);
      chk("dstall_pc",    pc,                  32'h1000_0400);
      chk("dstall_valid", {31'b0, instr_valid}, 32'd1);
    end

    do_adv(1'b0, 1'b1, 32'h3BFF_FEFE);
    chk("wrap_top",   pc,      32'hFFFF_FFFC);
    chk("wrap_plus4", pcplus4, 32'h0);
    do_fetch($urandom, 0);
    do_adv(1'b0, 1'b0, 32'h0);
    chk("wrap_zero", pc, 32'h0);
    do_fetch($urandom, 0);
    do_adv(1'b0, 1'b0, 32'h0);

    // Reset while a fetch is outstanding and memory answers in that cycle.
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mrst_req",   {31'b0, imem_req},    32'd0);
    chk("mrst_pc",    pc,                   RST_PC);
    chk("mrst_instr", instr,                32'h0);
    rst_n      = 1'b1;
    imem_ready = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      rst_n      = ($urandom_range(99) != 0);
      imem_ready = ($urandom_range(2) != 0);
      advance    = 1'($urandom);
      jump       = ($urandom_range(3) == 0);
      pcsrc      = 1'($urandom);
      signimm    = ($urandom_range(1) == 0) ? 32'($signed(8'($urandom))) : $urandom;
      imem_rdata = $urandom;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
